// File: rtl/lsu_mem_master.sv
// Load/store initiator: takes one load/store command and runs it on a req/ack word memory.
// Handles store lane replication and byte enables, load extension, and error reporting.
module lsu_mem_master #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] E_NONE    = 2'b00;
  localparam logic [1:0] E_MISALGN = 2'b01;
  localparam logic [1:0] E_ILLEGAL = 2'b10;
  localparam logic [1:0] E_TIMEOUT = 2'b11;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             op_store;
  logic [2:0]       op_f3;
  logic [1:0]       op_lane;
  logic [CNT_W-1:0] cnt_nxt;
  logic             timeout_hit;

  function automatic logic is_illegal(input logic st, input logic [2:0] f3);
    if (st) is_illegal = (f3 != 3'b000) && (f3 != 3'b001) && (f3 != 3'b010);
    else    is_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   is_misaligned = a[0];
      2'b10:   is_misaligned = (a != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   store_be = 4'b0001 << a;
      2'b01:   store_be = a[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   store_data = {4{d[7:0]}};
      2'b01:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] a,
                                          input logic [31:0] word);
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic signed [31:0] sx;
    sb = 8'(word >> {a, 3'b000});
    sh = a[1] ? word[31:16] : word[15:0];
    sx = '0;
    case (f3)
      3'b000:  begin sx = sb; extract = sx; end
      3'b001:  begin sx = sh; extract = sx; end
      3'b100:  extract = {24'd0, sb};
      3'b101:  extract = {16'd0, sh};
      default: extract = word;
    endcase
  endfunction

  assign cnt_nxt     = cnt + 1'b1;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_nxt == TO_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_store  <= 1'b0;
      op_f3     <= 3'b000;
      op_lane   <= 2'b00;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
      err_code  <= E_NONE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= 4'b0000;
    end else begin
      // err/err_code only carry meaning alongside the done pulse
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= E_NONE;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_store <= is_store;
            op_f3    <= funct3;
            op_lane  <= addr[1:0];
            busy     <= 1'b1;
            if (is_illegal(is_store, funct3)) begin
              state    <= S_DONE;
              done     <= 1'b1;
              err      <= 1'b1;
              err_code <= E_ILLEGAL;
            end else if (is_misaligned(funct3, addr[1:0])) begin
              state    <= S_DONE;
              done     <= 1'b1;
              err      <= 1'b1;
              err_code <= E_MISALGN;
            end else begin
              state     <= S_ACCESS;
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wdata <= is_store ? store_data(funct3, wdata) : 32'd0;
              mem_be    <= is_store ? store_be(funct3, addr[1:0]) : 4'b0000;
            end
          end
        end
        S_ACCESS: begin
          // an ack on the timeout edge still completes normally
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= S_DONE;
            done    <= 1'b1;
            if (!op_store) rdata <= extract(op_f3, op_lane, mem_rdata);
          end else if (timeout_hit) begin
            mem_req  <= 1'b0;
            state    <= S_DONE;
            done     <= 1'b1;
            err      <= 1'b1;
            err_code <= E_TIMEOUT;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: directed cases plus randomized commands against a
// transaction-level reference model and a scripted memory responder.
module tb_lsu_mem_master;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic [1:0]  err_code;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int          n_chk;
  int          n_pass;
  logic [31:0] model_rdata;

  lsu_mem_master #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .err(err), .err_code(err_code), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model: error classification, memory-side view and load result.
  function automatic logic [1:0] model_err(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int size;
    bit ok;
    ok = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!ok) return 2'd2;
    size = 1 << f3[1:0];
    if ((a % size) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int size;
    size = 1 << f3[1:0];
    return 4'(((1 << size) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'd0:    return (d & 32'hFF) * 32'h0101_0101;
      2'd1:    return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
    int bits;
    logic [31:0] mask;
    logic [31:0] v;
    bits = 8 * (1 << f3[1:0]);
    if (bits == 32) return w;
    mask = (32'd1 << bits) - 1;
    v = (w >> (8 * (a % 4))) & mask;
    if (f3[2] == 1'b0 && v >= (32'd1 << (bits - 1))) v = v | ~mask;
    return v;
  endfunction

  task automatic run_cmd(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rw, input int waits,
                         input bit poke);
    logic [1:0] code;
    bit tmo;
    int n_edges;
    @(negedge clk);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd; mem_ack = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    code = model_err(st, f3, a);
    chk("busy_after_start", busy, 1);
    if (code != 2'd0) begin
      chk("err_done", done, 1);
      chk("err_flag", err, 1);
      chk("err_code", err_code, code);
      chk("err_no_req", mem_req, 0);
    end else begin
      chk("req_issued", mem_req, 1);
      chk("done_early", done, 0);
      chk("mem_we", mem_we, st);
      chk("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
      chk("mem_be", mem_be, st ? model_be(f3, a) : 4'b0000);
      if (st) chk("mem_wdata", mem_wdata, model_wdata(f3, wd));
      tmo = (waits >= TO);
      n_edges = tmo ? TO : waits + 1;
      for (int i = 1; i <= n_edges; i++) begin
        @(negedge clk);
        mem_ack   = ((i - 1) == waits);
        mem_rdata = ((i - 1) == waits) ? rw : $urandom;
        if (poke) begin
          start = 1'($urandom % 2); is_store = 1'($urandom % 2);
          funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
        end
        @(posedge clk); #1;
        if (i < n_edges) begin
          chk("req_hold", mem_req, 1);
          chk("addr_hold", mem_addr, a & 32'hFFFF_FFFC);
          chk("no_done_wait", done, 0);
        end else begin
          if (!st && !tmo) model_rdata = model_load(f3, a, rw);
          chk("done_pulse", done, 1);
          chk("req_dropped", mem_req, 0);
          chk("err_at_done", err, tmo);
          chk("code_at_done", err_code, tmo ? 2'd3 : 2'd0);
          chk("rdata", rdata, model_rdata);
        end
      end
    end
    @(negedge clk);
    mem_ack = 1'($urandom % 2); mem_rdata = $urandom;
    start = poke ? 1'($urandom % 2) : 1'b0;
    @(posedge clk); #1;
    start = 1'b0; mem_ack = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("idle_again", busy, 0);
    chk("err_cleared", err, 0);
    chk("code_cleared", err_code, 0);
    chk("rdata_held", rdata, model_rdata);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; model_rdata = '0;
    rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0;
    addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", {err, err_code}, 0);
    chk("rst_req", {mem_req, mem_we, mem_be}, 0);
    chk("rst_addr", mem_addr, 0);
    @(negedge clk);
    rst = 1'b0;

    // directed cases
    run_cmd(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
    run_cmd(0, 3'b000, 32'h13, 32'h0, 32'h80FF0000, 3, 0);
    chk("lb_value", rdata, 32'hFFFFFF80);
    run_cmd(0, 3'b100, 32'h13, 32'h0, 32'h80FF0000, 3, 0);
    chk("lbu_value", rdata, 32'h00000080);
    run_cmd(1, 3'b001, 32'h06, 32'h1234ABCD, 32'h0, 1, 0);
    run_cmd(0, 3'b101, 32'h06, 32'h0, 32'hBEEF1111, 0, 0);
    chk("lhu_value", rdata, 32'h0000BEEF);
    run_cmd(0, 3'b010, 32'h02, 32'h0, 32'h0, 0, 0);
    run_cmd(1, 3'b011, 32'h20, 32'h0, 32'h0, 0, 0);
    run_cmd(0, 3'b010, 32'h40, 32'h0, 32'h12345678, 100, 1);
    run_cmd(0, 3'b010, 32'h40, 32'h0, 32'h12345678, TO - 1, 1);
    chk("ack_on_limit", rdata, 32'h12345678);

    // reset while a request is outstanding
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h80;
    @(posedge clk); #1;
    start = 1'b0;
    chk("pre_rst_req", mem_req, 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    model_rdata = '0;
    chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_rdata", rdata, model_rdata);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("no_done_after_rst", {done, busy}, 0);
    end

    // randomized commands
    for (int n = 0; n < 200; n++) begin
      logic [31:0] ra;
      ra = $urandom;
      if ($urandom % 2) ra = ra & 32'hFFFF_FFFC;
      run_cmd(1'($urandom % 2), 3'($urandom), ra, $urandom, $urandom,
              int'($urandom % 6), 1'($urandom % 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
